// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one imem read per
// instruction and holds the result for decode under valid/ready.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_rvalid,
    input  logic [31:0] inst_rdata,
    output logic        if_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc4_o,
    input  logic        npc_valid_i,
    input  logic [31:0] npc_i,
    output logic        misalign_o,
    output logic [31:0] fetch_cnt_o
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_WAIT,
        S_HOLD,
        S_NEXT,
        S_TRAP
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic [31:0] inst_q;
    logic [31:0] cnt_q;

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        inst_req   = 1'b0;
        if_valid_o = 1'b0;
        misalign_o = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                inst_req = ~cpu_rst;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                if (inst_rvalid) state_d = S_HOLD;
            end
            S_HOLD: begin
                if_valid_o = 1'b1;
                if (id_ready_i) state_d = S_NEXT;
            end
            S_NEXT: begin
                if (npc_valid_i) begin
                    state_d = (npc_i[1:0] == 2'b00) ? S_FETCH : S_TRAP;
                end
            end
            S_TRAP: begin
                misalign_o = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // NOP (addi x0,x0,0) is the idle instruction after reset
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            pc_q   <= RESET_PC;
            inst_q <= 32'h0000_0013;
            cnt_q  <= 32'h0000_0000;
        end else begin
            if (state_q == S_WAIT && inst_rvalid) begin
                inst_q <= inst_rdata;
            end
            if (state_q == S_HOLD && id_ready_i) begin
                cnt_q <= cnt_q + 32'd1;
            end
            if (state_q == S_NEXT && npc_valid_i) begin
                pc_q <= npc_i;
            end
        end
    end

    assign inst_addr   = pc_q;
    assign pc_o        = pc_q;
    assign pc4_o       = pc_q + 32'd4;
    assign inst_o      = inst_q;
    assign fetch_cnt_o = cnt_q;

endmodule
